alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, number of requesters (only 2 is supported).
REQ-002 The block SHALL have port clk  input  1  single rising-edge clock.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid/req1_valid  input  1  requester has an operation pending.
REQ-005 The block SHALL have ports req0_ready/req1_ready  output  1  operation accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  operands.
REQ-007 The block SHALL have ports req0_op/req1_op  input  4  op code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
REQ-008 The block SHALL have port rsp_valid  output  1  response held.
REQ-009 The block SHALL have port rsp_ready  input  1  consumer takes response.
REQ-010 The block SHALL have port rsp_id  output  1  requester index of response.
REQ-011 The block SHALL have ports rsp_result  output  32  and rsp_zero  output  1  result and zero flag.
REQ-012 The block SHALL have port rsp_err  output  1  unsupported op code.
REQ-013 The block SHALL have ports cnt0/cnt1  output  16  completed-response count per requester.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and RESP.
REQ-015 IDLE: reqN_ready SHALL be 1 only for the granted requester N, combinationally, when reqN_valid=1; a handshake captures a, b, op and id into registers and moves to EXEC.
REQ-016 Grant: a single valid requester SHALL win; when both are valid, the requester not served last SHALL win (round-robin pointer); the pointer SHALL flip to the other requester on each accept.
REQ-017 EXEC: the captured op SHALL be evaluated in one cycle and registered into rsp_result/rsp_zero/rsp_err; the FSM SHALL then go to RESP.
REQ-018 Arithmetic SHALL be 32-bit modulo 2^32: AND a&b; OR a|b; ADD a+b; SUB a-b.
REQ-019 rsp_zero SHALL be 1 only for SUB with a==b; for all other ops it SHALL be 0.
REQ-020 Any other op code SHALL give rsp_result=0, rsp_zero=0, rsp_err=1; for supported ops rsp_err SHALL be 0.
REQ-021 RESP: rsp_valid=1 and all rsp_* SHALL be held stable until rsp_ready=1; on that handshake cntN for rsp_id SHALL increment and the FSM SHALL return to IDLE.
REQ-022 Latency SHALL be: accept at cycle T, rsp_valid at T+2; minimum issue interval is 3 cycles.
REQ-023 Both ready outputs SHALL be 0 in EXEC and RESP; a requester held off SHALL keep valid asserted and is not dropped.
REQ-024 cntN SHALL saturate at 16'hFFFF.
REQ-025 A reqN_valid deasserted before handshake SHALL be treated as withdrawn with no side effect.

Reset
REQ-026 With reset=1 at a clock edge: state=IDLE, pointer prefers requester 0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, cnt0=cnt1=0.
REQ-027 reset during EXEC or RESP SHALL abandon the in-flight operation with no response and no count increment.
REQ-028 req0_ready and req1_ready SHALL be 0 while reset=1.

Structure
REQ-029 Op-code constants (AND, OR, ADD, SUB) and the FSM state encoding SHALL live in shared package alu_pkg.
REQ-030 Op evaluation SHALL be a combinational sub-module alu_exec (a, b, op -> result, zero, err); the FSM, pointer and counters stay in alu_arbiter.

Verification
REQ-031 After reset, req0 ADD a=5 b=7 -> req0_ready in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0; with rsp_ready=1 -> cnt0=1.
REQ-032 Both valid from reset, req0 SUB 9,9, req1 OR F0,0F -> req0 served first (result 0, zero 1), then req1 (result FF, zero 0, id 1).
REQ-033 Both valid continuously for 6 ops -> grants alternate 0,1,0,1,0,1; cnt0=cnt1=3.
REQ-034 rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, no ready pulses, then one handshake -> IDLE.
REQ-035 op=4'b1111 -> rsp_err=1, rsp_result=0; SUB 0,1 -> result FFFFFFFF; ADD FFFFFFFF,1 -> result 0, zero 0.
REQ-036 reset asserted in EXEC -> no rsp_valid, counters 0, next request is served normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter: op codes, widths, FSM encoding
// and a saturating counter helper.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/alu_exec.sv
// Combinational op evaluation. Zero flag is only meaningful for SUB
// (acts as an equality compare); unknown op codes flag an error and
// force the result to zero.
module alu_exec
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [3:0]        op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              err_o
);

    // Decode the op code and compute result/flags.
    always_comb begin
        result_o = '0;
        zero_o   = 1'b0;
        err_o    = 1'b0;
        case (op_i)
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_ADD: result_o = a_i + b_i;
            OP_SUB: begin
                result_o = a_i - b_i;
                zero_o   = (a_i == b_i);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a single-cycle ALU.
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1; valid may not depend on ready; a requester that loses
// arbitration simply keeps valid high and is served later.
// One operation is in flight at a time: IDLE (accept) -> EXEC -> RESP.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req0_op,
    input  logic [3:0]        req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output state_t            dbg_state_o
);

    localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
    logic [3:0]          op_q, op_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
    logic                rsp_zero_q, rsp_zero_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    logic                grant_valid;
    logic [ID_W-1:0]     grant_id;
    logic                accept;
    logic                rsp_done;
    logic [DATA_W-1:0]   alu_result;
    logic                alu_zero;
    logic                alu_err;

    alu_exec u_alu_exec (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .zero_o   (alu_zero),
        .err_o    (alu_err)
    );

    // Round-robin pick: a lone requester wins; on contention the pointer decides.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        if (req0_valid && (!req1_valid || ptr_q == '0)) begin
            grant_valid = 1'b1;
            grant_id    = '0;
        end else if (req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ID_W'(1);
        end
    end

    // FSM next state and handshake outputs; ready is suppressed during reset.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        rsp_done   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!reset && grant_valid) begin
                    accept     = 1'b1;
                    req0_ready = (grant_id == '0);
                    req1_ready = (grant_id != '0);
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next state: capture on accept, evaluate in EXEC, count on response.
    always_comb begin
        ptr_d        = ptr_q;
        id_d         = id_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        cnt0_d       = cnt0_q;
        cnt1_d       = cnt1_q;
        if (accept) begin
            ptr_d = ~grant_id;
            id_d  = grant_id;
            a_d   = (grant_id == '0) ? req0_a  : req1_a;
            b_d   = (grant_id == '0) ? req0_b  : req1_b;
            op_d  = (grant_id == '0) ? req0_op : req1_op;
        end
        if (state_q == ST_EXEC) begin
            rsp_id_d     = id_q;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
            rsp_err_d    = alu_err;
        end
        if (rsp_done) begin
            if (rsp_id_q == '0) cnt0_d = sat_inc(cnt0_q);
            else                cnt1_d = sat_inc(cnt1_q);
        end
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            id_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            cnt0_q       <= '0;
            cnt1_q       <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign rsp_id      = rsp_id_q[0];
    assign rsp_result  = rsp_result_q;
    assign rsp_zero    = rsp_zero_q;
    assign rsp_err     = rsp_err_q;
    assign cnt0        = cnt0_q;
    assign cnt1        = cnt1_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: inputs change on the falling edge,
// outputs are sampled on the falling edge (or 1ns after it).
module tb_alu_arbiter;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, rsp_err;
    logic [31:0] rsp_result;
    logic [15:0] cnt0, cnt1;
    state_t      dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] exp_q[$];

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_op(req0_op), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .cnt0(cnt0), .cnt1(cnt1), .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reset for two cycles with a requester pending, then check reset values.
    task automatic do_reset(input string tag);
        @(negedge clk);
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b0;
        #1 check({tag, "_rdy_in_rst"}, 64'(req0_ready), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; req0_valid = 1'b0;
        check({tag, "_state"},  64'(dbg_state),  64'(ST_IDLE));
        check({tag, "_rvalid"}, 64'(rsp_valid),  64'(0));
        check({tag, "_rsp"},    64'({rsp_id, rsp_zero, rsp_err, rsp_result}), 64'(0));
        check({tag, "_cnt"},    64'({cnt0, cnt1}), 64'(0));
    endtask

    // Issue one op from requester id and check exact latency and response.
    task automatic run_op(input string tag, input logic id, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] op,
                          input logic [31:0] er, input logic ez, input logic ee);
        @(negedge clk);
        if (!id) begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
        else     begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
        #1 check({tag, "_rdy"}, 64'({req1_ready, req0_ready}), id ? 64'(2) : 64'(1));
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        check({tag, "_exec_nv"}, 64'(rsp_valid), 64'(0));
        @(negedge clk);
        check({tag, "_valid"},  64'(rsp_valid),  64'(1));
        check({tag, "_id"},     64'(rsp_id),     64'(id));
        check({tag, "_result"}, 64'(rsp_result), 64'(er));
        check({tag, "_flags"},  64'({rsp_zero, rsp_err}), 64'({ez, ee}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_done"}, 64'(rsp_valid), 64'(0));
    endtask

    initial begin
        int n_grant;
        int n_rsp;
        logic [32:0] e;

        // Basic ADD with latency
        do_reset("rst1");
        run_op("t1_add", 1'b0, 32'd5, 32'd7, OP_ADD, 32'd12, 1'b0, 1'b0);
        check("t1_cnt", 64'({cnt0, cnt1}), 64'({16'd1, 16'd0}));

        // Contention from reset: req0 first, req1 waits
        do_reset("rst2");
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd9;    req0_b = 32'd9;    req0_op = OP_SUB;
        req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_op = OP_OR;
        #1 check("t2_grant0", 64'({req1_ready, req0_ready}), 64'(1));
        @(negedge clk);
        req0_valid = 1'b0;
        check("t2_exec_rdy", 64'({req1_ready, req0_ready}), 64'(0));
        @(negedge clk);
        check("t2_rsp0", 64'({rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result}),
              64'({1'b1, 1'b0, 1'b1, 1'b0, 32'd0}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t2_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("t2_grant1", 64'({req1_ready, req0_ready}), 64'(2));
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        check("t2_rsp1", 64'({rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result}),
              64'({1'b1, 1'b1, 1'b0, 1'b0, 32'hFF}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t2_cnt", 64'({cnt0, cnt1}), 64'({16'd1, 16'd1}));

        // Continuous contention: six alternating grants
        do_reset("rst3");
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd1;  req0_b = 32'd2; req0_op = OP_ADD;
        req1_valid = 1'b1; req1_a = 32'd10; req1_b = 32'd3; req1_op = OP_SUB;
        rsp_ready = 1'b1;
        n_grant = 0;
        n_rsp = 0;
        for (int cyc = 0; cyc < 60 && n_rsp < 6; cyc++) begin
            #1;
            if (n_grant == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            if (req0_ready || req1_ready) begin
                check("t3_grant_order", 64'(req1_ready), 64'(n_grant % 2));
                exp_q.push_back(req1_ready ? {1'b1, 32'd7} : {1'b0, 32'd3});
                n_grant++;
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("t3_unexpected_rsp", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("t3_rsp", 64'({rsp_id, rsp_result}), 64'(e));
                end
                n_rsp++;
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        check("t3_rsp_count", 64'(n_rsp), 64'(6));
        check("t3_cnt", 64'({cnt0, cnt1}), 64'({16'd3, 16'd3}));

        // Response back-pressure with a held-off requester
        do_reset("rst4");
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 32'hFF00FF00; req1_b = 32'h0FF0F0F0; req1_op = OP_AND;
        #1 check("t4_rdy1", 64'({req1_ready, req0_ready}), 64'(2));
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_op = OP_ADD;
        check("t4_exec_rdy", 64'({req1_ready, req0_ready}), 64'(0));
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold", 64'({rsp_valid, rsp_id, rsp_zero, rsp_err, rsp_result}),
                  64'({1'b1, 1'b1, 1'b0, 1'b0, 32'h0F00F000}));
            check("t4_hold_rdy", 64'({req1_ready, req0_ready}), 64'(0));
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t4_idle", 64'(dbg_state), 64'(ST_IDLE));
        check("t4_held_served", 64'({req1_ready, req0_ready}), 64'(1));
        check("t4_cnt1", 64'(cnt1), 64'(1));
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        check("t4_rsp0", 64'({rsp_valid, rsp_id, rsp_result}), 64'({1'b1, 1'b0, 32'd5}));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("t4_cnt0", 64'(cnt0), 64'(1));

        // Boundary ops
        run_op("t5_badop", 1'b0, 32'd3, 32'd4, 4'b1111, 32'd0, 1'b0, 1'b1);
        run_op("t5_sub_wrap", 1'b1, 32'd0, 32'd1, OP_SUB, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op("t5_add_wrap", 1'b0, 32'hFFFFFFFF, 32'd1, OP_ADD, 32'd0, 1'b0, 1'b0);
        run_op("t5_or", 1'b1, 32'h12340000, 32'h00005678, OP_OR, 32'h12345678, 1'b0, 1'b0);

        // Reset during EXEC abandons the operation
        do_reset("rst6");
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = OP_ADD;
        @(negedge clk);
        req0_valid = 1'b0;
        check("t6_in_exec", 64'(dbg_state), 64'(ST_EXEC));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        check("t6_no_rsp", 64'(rsp_valid), 64'(0));
        check("t6_cnt", 64'({cnt0, cnt1}), 64'(0));
        run_op("t6_after", 1'b1, 32'd4, 32'd4, OP_ADD, 32'd8, 1'b0, 1'b0);
        check("t6_cnt_after", 64'({cnt0, cnt1}), 64'({16'd0, 16'd1}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
